// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter and access sequencer for a
// shared 256 x 8 data memory with a combinational read port and a
// level-sensitive write port.
//
// Every access walks IDLE -> ACCESS -> DONE -> IDLE. All outputs are
// registered, so there is no combinational path from req* to any mem_*
// pin. mem_write can therefore only be high while mem_addr/mem_wdata are
// stable. A port may set lock with a request to keep ownership for its
// next access, which makes read-modify-write pairs atomic.
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   req0/1                access request, held until the matching ack
//   we0/1                 1 = write, 0 = read (sampled with the request)
//   lock0/1               keep the grant after this access completes
//   addr0/1, wdata0/1     access address and write data
//   ack0/1                one-cycle completion pulse
//   rdata0/1              registered read result, per port
//   mem_addr, mem_wdata   to memory Address / WriteData
//   mem_read, mem_write   to memory MemRead / MemWrite
//   mem_rdata             from memory ReadData
//   busy                  high in ACCESS and DONE
//   grant_id              port owning the current or last transaction
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_id
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic last;      // port served most recently (round-robin pointer)
    logic locked;    // owner keeps the grant for its next access
    logic owner;     // port holding the lock
    logic cur_we;
    logic cur_lock;

    logic              grant_valid;
    logic              grant_port;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic              sel_lock;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge value of its neighbours.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        state_next  = state;
        grant_valid = 1'b0;
        grant_port  = 1'b0;

        if (locked) begin
            // Only the lock owner is considered; the other port starves.
            grant_port  = owner;
            grant_valid = owner ? req1 : req0;
        end else if (req0 && req1) begin
            grant_valid = 1'b1;
            grant_port  = ~last;
        end else if (req0) begin
            grant_valid = 1'b1;
        end else if (req1) begin
            grant_valid = 1'b1;
            grant_port  = 1'b1;
        end

        sel_addr  = grant_port ? addr1  : addr0;
        sel_wdata = grant_port ? wdata1 : wdata0;
        sel_we    = grant_port ? we1    : we0;
        sel_lock  = grant_port ? lock1  : lock0;

        case (state)
            S_IDLE:   if (grant_valid) state_next = S_ACCESS;
            S_ACCESS: state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Registered outputs and transaction context. Each output is set on
    // the edge entering the state in which it must be visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            busy      <= 1'b0;
            grant_id  <= 1'b0;
            last      <= 1'b1;   // port 0 wins the first tie
            locked    <= 1'b0;
            owner     <= 1'b0;
            cur_we    <= 1'b0;
            cur_lock  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        grant_id  <= grant_port;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        cur_we    <= sel_we;
                        cur_lock  <= sel_lock;
                        mem_write <= sel_we;
                        mem_read  <= ~sel_we;
                        busy      <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    if (!cur_we) begin
                        if (grant_id) rdata1 <= mem_rdata;
                        else          rdata0 <= mem_rdata;
                    end
                    ack0 <= ~grant_id;
                    ack1 <= grant_id;
                end
                S_DONE: begin
                    ack0   <= 1'b0;
                    ack1   <= 1'b0;
                    busy   <= 1'b0;
                    last   <= grant_id;
                    locked <= cur_lock;
                    owner  <= grant_id;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a 256 x 8 behavioural memory.
module tb_mem_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, req1, we0, we1, lock0, lock1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       ack0, ack1;
    logic [7:0] rdata0, rdata1;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_read, mem_write, busy, grant_id;

    int tests_run    = 0;
    int tests_failed = 0;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .lock0     (lock0),
        .lock1     (lock1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: combinational read, write while mem_write high.
    logic [7:0] mem [256];
    logic       mem_loaded = 1'b0;
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[100] <= 8'h83;
            mem[101] <= 8'h11;
            mem[112] <= 8'hF5;
            mem[120] <= 8'hFF;
            mem_loaded <= 1'b1;
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Pulse/level counters sampled mid-cycle.
    int ack0_cnt = 0, ack1_cnt = 0, rd_cycles = 0, wr_cycles = 0;
    always @(negedge clk) begin
        if (ack0)      ack0_cnt++;
        if (ack1)      ack1_cnt++;
        if (mem_read)  rd_cycles++;
        if (mem_write) wr_cycles++;
    end

    int ack_port [8];
    int ack_cyc  [8];
    int n_acks;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run until 'want' acks are seen or the budget expires. With hold=0 a
    // port's request drops on its ack; with hold=1 requests stay up until
    // the last wanted ack.
    task automatic collect(input string name, input int want, input int budget, input bit hold);
        n_acks = 0;
        for (int c = 1; c <= budget && n_acks < want; c++) begin
            tick();
            if (ack0 && n_acks < 8) begin
                ack_port[n_acks] = 0; ack_cyc[n_acks] = c; n_acks++;
                if (!hold) req0 = 1'b0;
            end
            if (ack1 && n_acks < 8) begin
                ack_port[n_acks] = 1; ack_cyc[n_acks] = c; n_acks++;
                if (!hold) req1 = 1'b0;
            end
            if (n_acks >= want) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        tests_run++;
        if (n_acks < want) begin
            tests_failed++;
            $display("FAIL %s_timeout: got %0d acks, expected %0d", name, n_acks, want);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        tick(); tick(); tick();
        tests_run++;
        if ({ack0, ack1, mem_read, mem_write, busy, grant_id} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {ack0, ack1, mem_read, mem_write, busy, grant_id});
        end
        tests_run++;
        if ({mem_addr, mem_wdata, rdata0, rdata1} !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h expected 00000000",
                     {mem_addr, mem_wdata, rdata0, rdata1});
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_read();
        int rd0;
        rd0 = rd_cycles;
        addr0 = 8'd100; we0 = 1'b0; lock0 = 1'b0; req0 = 1'b1;
        tick();  // ACCESS
        tests_run++;
        if ({mem_read, mem_write, busy, grant_id} !== 4'b1010 || mem_addr !== 8'd100) begin
            tests_failed++;
            $display("FAIL read_access: got rd/wr/busy/gid=%b addr=%0d expected 1010 addr=100",
                     {mem_read, mem_write, busy, grant_id}, mem_addr);
        end
        tick();  // DONE
        tests_run++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0 || mem_read !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_ack: got ack0=%b ack1=%b mem_read=%b expected 1 0 0", ack0, ack1, mem_read);
        end
        tests_run++;
        if (rdata0 !== 8'h83 || rdata1 !== 8'h00) begin
            tests_failed++;
            $display("FAIL read_rdata: got rdata0=%h rdata1=%h expected 83 00", rdata0, rdata1);
        end
        req0 = 1'b0;
        tick();  // IDLE
        tests_run++;
        if (ack0 !== 1'b0 || busy !== 1'b0 || (rd_cycles - rd0) !== 1) begin
            tests_failed++;
            $display("FAIL read_end: got ack0=%b busy=%b rd_cycles=%0d expected 0 0 1",
                     ack0, busy, rd_cycles - rd0);
        end
    endtask

    task automatic test_write_read();
        int a0, wr0;
        a0 = ack0_cnt; wr0 = wr_cycles;
        addr1 = 8'd200; wdata1 = 8'h5A; we1 = 1'b1; lock1 = 1'b0; req1 = 1'b1;
        tick();  // ACCESS
        tests_run++;
        if ({mem_write, mem_read, grant_id} !== 3'b101 || mem_addr !== 8'd200 || mem_wdata !== 8'h5A) begin
            tests_failed++;
            $display("FAIL write_access: got wr/rd/gid=%b addr=%0d wdata=%h expected 101 200 5a",
                     {mem_write, mem_read, grant_id}, mem_addr, mem_wdata);
        end
        tick();  // DONE
        tests_run++;
        if (ack1 !== 1'b1 || mem_write !== 1'b0 || rdata1 !== 8'h00) begin
            tests_failed++;
            $display("FAIL write_ack: got ack1=%b mem_write=%b rdata1=%h expected 1 0 00",
                     ack1, mem_write, rdata1);
        end
        we1 = 1'b0;  // next request: read back
        collect("write_readback", 1, 10, 1'b0);
        tests_run++;
        if (rdata1 !== 8'h5A || mem[200] !== 8'h5A || (wr_cycles - wr0) !== 1) begin
            tests_failed++;
            $display("FAIL write_readback: got rdata1=%h mem=%h wr_cycles=%0d expected 5a 5a 1",
                     rdata1, mem[200], wr_cycles - wr0);
        end
        tests_run++;
        if ((ack0_cnt - a0) !== 0 || rdata0 !== 8'h83) begin
            tests_failed++;
            $display("FAIL write_port0_quiet: got ack0 pulses=%0d rdata0=%h expected 0 83",
                     ack0_cnt - a0, rdata0);
        end
    endtask

    task automatic test_contention();
        addr0 = 8'd112; we0 = 1'b0; lock0 = 1'b0;
        addr1 = 8'd120; we1 = 1'b0; lock1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        collect("contention", 4, 20, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (ack_port[i] !== (i % 2) || ack_cyc[i] !== 2 + 3 * i) begin
                tests_failed++;
                $display("FAIL contention_ack%0d: got port=%0d cycle=%0d expected port=%0d cycle=%0d",
                         i, ack_port[i], ack_cyc[i], i % 2, 2 + 3 * i);
            end
        end
        tests_run++;
        if (rdata0 !== 8'hF5 || rdata1 !== 8'hFF) begin
            tests_failed++;
            $display("FAIL contention_rdata: got %h %h expected f5 ff", rdata0, rdata1);
        end
    endtask

    task automatic test_lock();
        int order [3];
        int n, n1;
        n = 0; n1 = 0;
        addr1 = 8'd101; we1 = 1'b0; lock1 = 1'b1; wdata1 = 8'h3C; req1 = 1'b1;
        tick();  // port 1 in ACCESS
        addr0 = 8'd100; we0 = 1'b0; lock0 = 1'b0; req0 = 1'b1;
        for (int c = 0; c < 25 && n < 3; c++) begin
            tick();
            if (ack1) begin
                order[n] = 1; n++; n1++;
                if (n1 == 1) begin
                    we1 = 1'b1; lock1 = 1'b0;  // locked write ends the pair
                end else begin
                    req1 = 1'b0;
                end
            end
            if (ack0 && n < 3) begin
                order[n] = 0; n++;
                req0 = 1'b0;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        tests_run++;
        if (n !== 3) begin
            tests_failed++;
            $display("FAIL lock_timeout: got %0d acks expected 3", n);
        end else begin
            tests_run++;
            if (order[0] !== 1 || order[1] !== 1 || order[2] !== 0) begin
                tests_failed++;
                $display("FAIL lock_order: got %0d%0d%0d expected 110", order[0], order[1], order[2]);
            end
        end
        tests_run++;
        if (rdata1 !== 8'h11 || mem[101] !== 8'h3C || rdata0 !== 8'h83) begin
            tests_failed++;
            $display("FAIL lock_data: got rdata1=%h mem101=%h rdata0=%h expected 11 3c 83",
                     rdata1, mem[101], rdata0);
        end
    endtask

    task automatic test_reset_mid();
        int a0, a1;
        addr0 = 8'd112; we0 = 1'b0; lock0 = 1'b0; req0 = 1'b1;
        tick();  // ACCESS
        tests_run++;
        if (mem_read !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_pre: got mem_read=%b expected 1", mem_read);
        end
        a0 = ack0_cnt; a1 = ack1_cnt;
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if ({mem_read, mem_write, busy, ack0, ack1, grant_id} !== 6'b0 ||
            {mem_addr, mem_wdata, rdata0, rdata1} !== 32'h0) begin
            tests_failed++;
            $display("FAIL midrst_async: got ctrl=%b data=%h expected 000000 00000000",
                     {mem_read, mem_write, busy, ack0, ack1, grant_id},
                     {mem_addr, mem_wdata, rdata0, rdata1});
        end
        req0 = 1'b0;
        tick(); tick();
        @(negedge clk);
        rst = 1'b1;
        tick(); tick(); tick();
        tests_run++;
        if ((ack0_cnt - a0) !== 0 || (ack1_cnt - a1) !== 0 || busy !== 1'b0 || rdata0 !== 8'h00) begin
            tests_failed++;
            $display("FAIL midrst_noack: got acks=%0d/%0d busy=%b rdata0=%h expected 0/0 0 00",
                     ack0_cnt - a0, ack1_cnt - a1, busy, rdata0);
        end
        // Tie after reset: port 0 must win because last resets to 1.
        addr0 = 8'd112; we0 = 1'b0; addr1 = 8'd100; we1 = 1'b0; lock1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        collect("midrst_tie", 2, 15, 1'b0);
        tests_run++;
        if (ack_port[0] !== 0 || ack_port[1] !== 1 || rdata0 !== 8'hF5 || rdata1 !== 8'h83) begin
            tests_failed++;
            $display("FAIL midrst_tie: got order=%0d%0d rdata=%h %h expected 01 f5 83",
                     ack_port[0], ack_port[1], rdata0, rdata1);
        end
    endtask

    task automatic test_idle();
        int bad;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_read !== 1'b0 || mem_write !== 1'b0 || busy !== 1'b0 || mem_addr !== 8'd100)
                bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL idle_hold: got %0d bad cycles expected 0 (last rd=%b wr=%b busy=%b addr=%0d)",
                     bad, mem_read, mem_write, busy, mem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_read();
        test_contention();
        test_lock();
        test_reset_mid();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
